// File: rtl/sc_io_port_unit_if.sv
// CPU-side load/store bus of the I/O responder.
interface sc_io_port_unit_if;
  logic [31:0] io_addr;
  logic [31:0] io_wdata;
  logic        io_we;
  logic        io_re;
  logic [31:0] io_rdata;
  logic        io_rvalid;

  modport master (output io_addr, io_wdata, io_we, io_re, input io_rdata, io_rvalid);
  modport slave  (input io_addr, io_wdata, io_we, io_re, output io_rdata, io_rvalid);
endinterface

// File: rtl/sc_io_port_unit.sv
// Memory-mapped I/O responder: OUT0..2 registers, synchronised IN0/1, sticky change STATUS + IRQ.
// Optional input debouncer enabled by defining IO_DEBOUNCE_EN.
module sc_io_port_unit #(
  parameter logic [23:0] IO_BASE    = 24'hFFFFFF,
  parameter int          OUT_W      = 5,
  parameter int          DEB_CYCLES = 16
) (
  input  logic                clock,
  input  logic                reset,
  sc_io_port_unit_if.slave    bus,
  output logic                io_irq,
  input  logic [31:0]         in_port0,
  input  logic [31:0]         in_port1,
  output logic [OUT_W-1:0]    out_port0,
  output logic [OUT_W-1:0]    out_port1,
  output logic [OUT_W-1:0]    out_port2
);
  logic [1:0][31:0]      s1_q, s1_d, s2_q, s2_d, in_q, in_d;
  logic [2:0][OUT_W-1:0] out_q, out_d;
  logic [1:0]            mask_q, mask_d, status_q, status_d, chg;
  logic [31:0]           rdata_q, rdata_d, rd_mux;
  logic                  rvalid_q, rvalid_d, irq_q, irq_d;
  logic                  sel, wr, rd;
  logic [5:0]            off;
  logic                  unused_bits;

  assign sel = (bus.io_addr[31:8] == IO_BASE);
  assign off = bus.io_addr[7:2];
  assign wr  = sel & bus.io_we;
  assign rd  = sel & bus.io_re;
  assign unused_bits = ^{bus.io_addr[1:0], bus.io_wdata[31:OUT_W]};

`ifdef IO_DEBOUNCE_EN
  localparam int CW = $clog2(DEB_CYCLES + 1);
  logic [1:0][31:0]   last_q, last_d;
  logic [1:0][CW-1:0] cnt_q, cnt_d;

  // A port is accepted only after sync2 has held still for DEB_CYCLES edges.
  always_comb begin
    last_d = s2_q;
    cnt_d  = cnt_q;
    in_d   = in_q;
    for (int i = 0; i < 2; i++) begin
      if (s2_q[i] != last_q[i])             cnt_d[i] = '0;
      else if (cnt_q[i] != CW'(DEB_CYCLES)) cnt_d[i] = cnt_q[i] + 1'b1;
      if (cnt_q[i] == CW'(DEB_CYCLES))      in_d[i]  = s2_q[i];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last_q <= '0;
      cnt_q  <= '0;
    end else begin
      last_q <= last_d;
      cnt_q  <= cnt_d;
    end
  end
`else
  assign in_d = s2_q;
`endif

  always_comb begin
    s1_d = {in_port1, in_port0};
    s2_d = s1_q;
    for (int i = 0; i < 2; i++) chg[i] = (in_d[i] != in_q[i]);

    rd_mux = '0;
    case (off)
      6'd0: rd_mux = in_q[0];
      6'd1: rd_mux = in_q[1];
      6'd2: rd_mux = {30'b0, status_q};
      6'd3: rd_mux = {30'b0, mask_q};
      6'd4: rd_mux = 32'(out_q[0]);
      6'd5: rd_mux = 32'(out_q[1]);
      6'd6: rd_mux = 32'(out_q[2]);
      default: rd_mux = '0;
    endcase
    rdata_d  = rd ? rd_mux : '0;
    rvalid_d = rd;

    // Clear-on-read uses the pre-clear value above; a same-edge set wins.
    status_d = ((rd && off == 6'd2) ? 2'b00 : status_q) | chg;

    mask_d = mask_q;
    out_d  = out_q;
    if (wr) begin
      case (off)
        6'd3: mask_d   = bus.io_wdata[1:0];
        6'd4: out_d[0] = bus.io_wdata[OUT_W-1:0];
        6'd5: out_d[1] = bus.io_wdata[OUT_W-1:0];
        6'd6: out_d[2] = bus.io_wdata[OUT_W-1:0];
        default: ;
      endcase
    end
    irq_d = |(status_q & mask_q);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_q     <= '0;
      s2_q     <= '0;
      in_q     <= '0;
      out_q    <= '0;
      mask_q   <= '0;
      status_q <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      in_q     <= in_d;
      out_q    <= out_d;
      mask_q   <= mask_d;
      status_q <= status_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      irq_q    <= irq_d;
    end
  end

  assign bus.io_rdata  = rdata_q;
  assign bus.io_rvalid = rvalid_q;
  assign io_irq        = irq_q;
  assign out_port0     = out_q[0];
  assign out_port1     = out_q[1];
  assign out_port2     = out_q[2];
endmodule

// File: tb/tb_sc_io_port_unit.sv
// Randomised + directed bench for sc_io_port_unit against a register-map level reference model.
module tb_sc_io_port_unit;
  localparam int DEB = 4;
`ifdef IO_DEBOUNCE_EN
  localparam int LAT = DEB + 3;
`else
  localparam int LAT = 3;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        io_irq;
  logic [31:0] in_port0 = '0, in_port1 = '0;
  logic [4:0]  out_port0, out_port1, out_port2;
  int          nvec = 0, nerr = 0;

  sc_io_port_unit_if io ();

  sc_io_port_unit #(.IO_BASE(24'hFFFFFF), .OUT_W(5), .DEB_CYCLES(DEB)) dut (
    .clock(clock), .reset(reset), .bus(io), .io_irq(io_irq),
    .in_port0(in_port0), .in_port1(in_port1),
    .out_port0(out_port0), .out_port1(out_port1), .out_port2(out_port2));

  always #5 clock = ~clock;

  // Reference state: register map values plus the raw port samples of the last three edges.
  logic [31:0] m_acc [2];
  logic [31:0] m_hist [3][2];
  int          m_cnt [2];
  logic [4:0]  m_out [3];
  logic [1:0]  m_mask, m_status;
  logic [31:0] m_rdata;
  logic        m_rvalid, m_irq;

  function automatic logic [31:0] reg_value(input logic [7:0] off);
    case (off)
      8'h00: return m_acc[0];
      8'h04: return m_acc[1];
      8'h08: return {30'b0, m_status};
      8'h0C: return {30'b0, m_mask};
      8'h10: return {27'b0, m_out[0]};
      8'h14: return {27'b0, m_out[1]};
      8'h18: return {27'b0, m_out[2]};
      default: return 32'h0;
    endcase
  endfunction

  task automatic tick();
    logic [31:0] nacc [2];
    logic [1:0]  set;
    logic        hit;
    logic [7:0]  off;
    @(posedge clock);
    hit = (io.io_addr[31:8] == 24'hFFFFFF);
    off = io.io_addr[7:0] & 8'hFC;
    if (reset) begin
      for (int p = 0; p < 2; p++) begin
        m_acc[p] = '0; m_cnt[p] = 0;
        for (int k = 0; k < 3; k++) m_hist[k][p] = '0;
      end
      for (int k = 0; k < 3; k++) m_out[k] = '0;
      m_mask = '0; m_status = '0; m_rdata = '0; m_rvalid = 0; m_irq = 0;
    end else begin
      m_irq    = |(m_status & m_mask);
      m_rvalid = io.io_re && hit;
      m_rdata  = m_rvalid ? reg_value(off) : 32'h0;
      for (int p = 0; p < 2; p++) begin
        // port value seen two edges ago is what sync2 holds now
`ifdef IO_DEBOUNCE_EN
        nacc[p] = (m_cnt[p] == DEB) ? m_hist[1][p] : m_acc[p];
        if (m_hist[1][p] != m_hist[2][p]) m_cnt[p] = 0;
        else if (m_cnt[p] < DEB)          m_cnt[p] = m_cnt[p] + 1;
`else
        nacc[p] = m_hist[1][p];
`endif
        set[p] = (nacc[p] != m_acc[p]);
      end
      m_status = ((m_rvalid && off == 8'h08) ? 2'b00 : m_status) | set;
      if (io.io_we && hit) begin
        case (off)
          8'h0C: m_mask   = io.io_wdata[1:0];
          8'h10: m_out[0] = io.io_wdata[4:0];
          8'h14: m_out[1] = io.io_wdata[4:0];
          8'h18: m_out[2] = io.io_wdata[4:0];
          default: ;
        endcase
      end
      for (int p = 0; p < 2; p++) begin
        m_hist[2][p] = m_hist[1][p];
        m_hist[1][p] = m_hist[0][p];
        m_acc[p]     = nacc[p];
      end
      m_hist[0][0] = in_port0;
      m_hist[0][1] = in_port1;
    end
    #1;
  endtask

  task automatic cyc(input logic we, input logic re, input logic [31:0] addr, input logic [31:0] wdata);
    io.io_we = we; io.io_re = re; io.io_addr = addr; io.io_wdata = wdata;
    tick();
    io.io_we = 0; io.io_re = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    reset = 1; idle(2);
    nvec++; if ({out_port0, out_port1, out_port2} !== 15'h0) begin nerr++; $display("FAIL reset_outs got %h exp 0", {out_port0, out_port1, out_port2}); end
    nvec++; if (io.io_rvalid !== 1'b0 || io.io_rdata !== 32'h0) begin nerr++; $display("FAIL reset_rd got %b/%h exp 0/0", io.io_rvalid, io.io_rdata); end
    nvec++; if (io_irq !== 1'b0) begin nerr++; $display("FAIL reset_irq got %b exp 0", io_irq); end
    reset = 0;
  endtask

  task automatic test_out_store();
    cyc(1, 0, 32'hFFFFFF10, 32'h13);
    nvec++; if (out_port0 !== 5'h13 || out_port0 !== m_out[0]) begin nerr++; $display("FAIL out0_store got %h exp %h", out_port0, 5'h13); end
    cyc(0, 1, 32'hFFFFFF10, 0);
    nvec++; if (io.io_rvalid !== 1'b1 || io.io_rdata !== 32'h13) begin nerr++; $display("FAIL out0_read got %b/%h exp 1/00000013", io.io_rvalid, io.io_rdata); end
    tick();
    nvec++; if (io.io_rvalid !== 1'b0 || io.io_rdata !== 32'h0) begin nerr++; $display("FAIL rvalid_pulse got %b/%h exp 0/0", io.io_rvalid, io.io_rdata); end
  endtask

  task automatic test_in_ports();
    in_port0 = 32'd15; in_port1 = 32'd7;
    idle(LAT + 1);
    cyc(0, 1, 32'hFFFFFF00, 0);
    nvec++; if (io.io_rvalid !== 1'b1 || io.io_rdata !== 32'd15 || io.io_rdata !== m_rdata) begin nerr++; $display("FAIL in0_read got %b/%h exp 1/%h", io.io_rvalid, io.io_rdata, 32'd15); end
    cyc(0, 1, 32'hFFFFFF04, 0);
    nvec++; if (io.io_rvalid !== 1'b1 || io.io_rdata !== 32'd7) begin nerr++; $display("FAIL in1_read got %b/%h exp 1/%h", io.io_rvalid, io.io_rdata, 32'd7); end
  endtask

  task automatic test_status();
    cyc(0, 1, 32'hFFFFFF08, 0);
    nvec++; if (io.io_rdata !== 32'h3 || io.io_rdata !== m_rdata) begin nerr++; $display("FAIL status_first got %h exp 3", io.io_rdata); end
    cyc(0, 1, 32'hFFFFFF08, 0);
    nvec++; if (io.io_rdata !== 32'h0) begin nerr++; $display("FAIL status_cleared got %h exp 0", io.io_rdata); end
    // the accepted change of in_port1 lands exactly on the clearing read edge
    in_port1 = 32'd8;
    idle(LAT - 1);
    cyc(0, 1, 32'hFFFFFF08, 0);
    nvec++; if (io.io_rdata !== 32'h0 || io.io_rdata !== m_rdata) begin nerr++; $display("FAIL status_race_read got %h exp 0", io.io_rdata); end
    cyc(0, 1, 32'hFFFFFF08, 0);
    nvec++; if (io.io_rdata !== 32'h2) begin nerr++; $display("FAIL status_set_wins got %h exp 2", io.io_rdata); end
  endtask

  task automatic test_irq();
    cyc(1, 0, 32'hFFFFFF0C, 32'h1);
    in_port0 = 32'd16;
    idle(LAT);
    nvec++; if (io_irq !== 1'b0) begin nerr++; $display("FAIL irq_lag got %b exp 0", io_irq); end
    tick();
    nvec++; if (io_irq !== 1'b1 || io_irq !== m_irq) begin nerr++; $display("FAIL irq_rise got %b exp 1", io_irq); end
    cyc(0, 1, 32'hFFFFFF08, 0);
    nvec++; if (io.io_rdata !== 32'h1) begin nerr++; $display("FAIL irq_status got %h exp 1", io.io_rdata); end
    tick();
    nvec++; if (io_irq !== 1'b0) begin nerr++; $display("FAIL irq_clear got %b exp 0", io_irq); end
  endtask

  task automatic test_rw_same();
    cyc(1, 0, 32'hFFFFFF14, 32'h04);
    cyc(1, 1, 32'hFFFFFF14, 32'h1F);
    nvec++; if (io.io_rdata !== 32'h04 || io.io_rvalid !== 1'b1) begin nerr++; $display("FAIL rw_old_value got %b/%h exp 1/4", io.io_rvalid, io.io_rdata); end
    nvec++; if (out_port1 !== 5'h1F) begin nerr++; $display("FAIL rw_commit got %h exp 1f", out_port1); end
    cyc(1, 0, 32'hFFFFFF00, 32'hDEAD);
    cyc(0, 1, 32'hFFFFFF00, 0);
    nvec++; if (io.io_rdata !== 32'd16 || io.io_rdata !== m_rdata) begin nerr++; $display("FAIL ro_store got %h exp %h", io.io_rdata, 32'd16); end
  endtask

  task automatic test_unmapped_reset();
    cyc(0, 1, 32'hFFFFFF40, 0);
    nvec++; if (io.io_rvalid !== 1'b1 || io.io_rdata !== 32'h0) begin nerr++; $display("FAIL unmapped got %b/%h exp 1/0", io.io_rvalid, io.io_rdata); end
    cyc(1, 1, 32'h12345610, 32'h1);
    nvec++; if (io.io_rvalid !== 1'b0 || out_port0 !== 5'h13) begin nerr++; $display("FAIL no_sel got %b/%h exp 0/13", io.io_rvalid, out_port0); end
    io.io_re = 1; io.io_addr = 32'hFFFFFF10; reset = 1;
    tick();
    io.io_re = 0; reset = 0;
    nvec++; if (io.io_rvalid !== 1'b0 || out_port0 !== 5'h0) begin nerr++; $display("FAIL reset_cancel got %b/%h exp 0/0", io.io_rvalid, out_port0); end
  endtask

`ifdef IO_DEBOUNCE_EN
  task automatic test_debounce();
    for (int i = 0; i < 30; i++) begin
      if (i % 2 == 0) in_port0 = (in_port0 == 32'hA) ? 32'h5 : 32'hA;
      tick();
    end
    cyc(0, 1, 32'hFFFFFF00, 0);
    nvec++; if (io.io_rdata !== 32'h0 || io.io_rdata !== m_rdata) begin nerr++; $display("FAIL debounce_hold got %h exp 0", io.io_rdata); end
  endtask
`endif

  task automatic test_random();
    logic [7:0] offs [9];
    logic [7:0] o;
    offs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C, 8'h41};
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(7) == 0) in_port0 = $urandom;
      if ($urandom_range(7) == 0) in_port1 = $urandom;
      o = offs[$urandom_range(8)];
      cyc($urandom_range(1), $urandom_range(1),
          ($urandom_range(9) == 0) ? {24'hFFFFFE, o} : {24'hFFFFFF, o}, $urandom);
      nvec++; if (io.io_rvalid !== m_rvalid || io.io_rdata !== m_rdata) begin nerr++; $display("FAIL rand_rd[%0d] got %b/%h exp %b/%h", i, io.io_rvalid, io.io_rdata, m_rvalid, m_rdata); end
      nvec++; if (out_port0 !== m_out[0] || out_port1 !== m_out[1] || out_port2 !== m_out[2]) begin nerr++; $display("FAIL rand_out[%0d] got %h %h %h exp %h %h %h", i, out_port0, out_port1, out_port2, m_out[0], m_out[1], m_out[2]); end
      nvec++; if (io_irq !== m_irq) begin nerr++; $display("FAIL rand_irq[%0d] got %b exp %b", i, io_irq, m_irq); end
    end
  endtask

  initial begin
    io.io_we = 0; io.io_re = 0; io.io_addr = '0; io.io_wdata = '0;
    test_reset();
    test_out_store();
    test_in_ports();
    test_status();
    test_irq();
    test_rw_same();
    test_unmapped_reset();
`ifdef IO_DEBOUNCE_EN
    test_debounce();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
